// File: rtl/rx_edge_bit_sampler.sv
// UART RX timing stage: 2-flop line synchroniser, oversample edge/bit counters
// and a three-point majority-vote bit sampler centred on the middle of each bit.
module rx_edge_bit_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int BIT_CNT_W   = 5,
  parameter int BIT_CNT_MAX = 31
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  edge_bit_enable,
  input  logic                  data_sampler_enable,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  prescale_err
);

  localparam int EW = PRESCALE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HAVE_S0,
    ST_HAVE_S1
  } vote_st_e;

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [PRESCALE_W-1:0] edge_count_q, edge_count_d;
  logic [BIT_CNT_W-1:0]  bit_count_q, bit_count_d;
  logic                  bit_done_q, bit_done_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  prescale_err_q, prescale_err_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  vote_st_e              vote_st_q, vote_st_d;

  logic                  prescale_ok;
  logic [EW-1:0]         edge_ext;
  logic [EW-1:0]         prescale_ext;
  logic [EW-1:0]         mid;
  logic                  wrap;
  logic                  sampler_on;
  logic                  majority;

  assign prescale_ok  = (prescale == PRESCALE_W'(4))  || (prescale == PRESCALE_W'(8)) ||
                        (prescale == PRESCALE_W'(16)) || (prescale == PRESCALE_W'(32));
  assign edge_ext     = {1'b0, edge_count_q};
  assign prescale_ext = {1'b0, prescale};
  assign mid          = prescale_ext >> 1;
  // Widened compare so a prescale lowered mid-bit (or zero) forces a wrap.
  assign wrap         = (edge_ext + EW'(1)) >= prescale_ext;
  assign sampler_on   = edge_bit_enable && data_sampler_enable && prescale_ok;
  assign majority     = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

  always_comb begin
    sync1_d        = RX_IN;
    sync2_d        = sync1_q;
    edge_count_d   = edge_count_q;
    bit_count_d    = bit_count_q;
    bit_done_d     = 1'b0;
    prescale_err_d = !prescale_ok;

    if (!edge_bit_enable) begin
      edge_count_d = '0;
      bit_count_d  = '0;
    end else if (wrap) begin
      edge_count_d = '0;
      bit_done_d   = 1'b1;
      if (bit_count_q != BIT_CNT_W'(BIT_CNT_MAX)) begin
        bit_count_d = bit_count_q + BIT_CNT_W'(1);
      end
    end else begin
      edge_count_d = edge_count_q + PRESCALE_W'(1);
    end

    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    vote_st_d      = ST_IDLE;

    // The vote needs an unbroken enabled run over mid-1, mid, mid+1.
    if (!sampler_on) begin
      s0_d = 1'b1;
      s1_d = 1'b1;
    end else if (edge_ext == mid - EW'(1)) begin
      s0_d      = sync2_q;
      vote_st_d = ST_HAVE_S0;
    end else if (edge_ext == mid) begin
      s1_d      = sync2_q;
      vote_st_d = (vote_st_q == ST_HAVE_S0) ? ST_HAVE_S1 : ST_IDLE;
    end else if ((edge_ext == mid + EW'(1)) && (vote_st_q == ST_HAVE_S1)) begin
      sampled_bit_d  = majority;
      sample_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      edge_count_q   <= '0;
      bit_count_q    <= '0;
      bit_done_q     <= 1'b0;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      prescale_err_q <= 1'b0;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      vote_st_q      <= ST_IDLE;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_count_q   <= edge_count_d;
      bit_count_q    <= bit_count_d;
      bit_done_q     <= bit_done_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      prescale_err_q <= prescale_err_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      vote_st_q      <= vote_st_d;
    end
  end

  assign rx_sync      = sync2_q;
  assign edge_count   = edge_count_q;
  assign bit_count    = bit_count_q;
  assign bit_done     = bit_done_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign prescale_err = prescale_err_q;

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Bench for rx_edge_bit_sampler: directed frame/glitch/boundary cases plus
// randomized enables, line and prescale checked against a cycle reference model.
module tb_rx_edge_bit_sampler;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       ebe;
  logic       dse;
  logic       rx_sync;
  logic [5:0] edge_count;
  logic [4:0] bit_count;
  logic       bit_done;
  logic       sampled_bit;
  logic       sample_valid;
  logic       prescale_err;

  int n_pass;
  int n_checks;

  // reference model state
  bit m_sync;
  bit rxq[$];
  int m_ec;
  int m_bc;
  bit m_bd;
  bit m_sb;
  bit m_sv;
  bit m_perr;
  bit h_act[2];
  int h_edge[2];
  bit h_rx[2];

  rx_edge_bit_sampler dut (
    .clk_based_on_prescale(clk),
    .asy_reset            (rst_n),
    .RX_IN                (rx_in),
    .prescale             (prescale),
    .edge_bit_enable      (ebe),
    .data_sampler_enable  (dse),
    .rx_sync              (rx_sync),
    .edge_count           (edge_count),
    .bit_count            (bit_count),
    .bit_done             (bit_done),
    .sampled_bit          (sampled_bit),
    .sample_valid         (sample_valid),
    .prescale_err         (prescale_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit legal(input int p);
    return (p == 4) || (p == 8) || (p == 16) || (p == 32);
  endfunction

  task automatic model_reset();
    rxq.delete();
    rxq.push_back(1'b1);
    m_sync = 1'b1;
    m_ec = 0;
    m_bc = 0;
    m_bd = 1'b0;
    m_sb = 1'b1;
    m_sv = 1'b0;
    m_perr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      h_act[k] = 1'b0;
      h_edge[k] = 0;
      h_rx[k] = 1'b1;
    end
  endtask

  // One clock of the reference: a vote happens when this cycle and the two
  // before it were all enabled and sat at mid+1, mid, mid-1 respectively.
  task automatic model_step();
    int p;
    int mid;
    bit act;
    bit n_sb;
    bit n_sv;
    p = int'(prescale);
    mid = p / 2;
    act = ebe && dse && legal(p);
    n_sb = m_sb;
    n_sv = 1'b0;
    if (act && m_ec == mid + 1 && h_act[1] && h_edge[1] == mid && h_act[0] && h_edge[0] == mid - 1) begin
      n_sv = 1'b1;
      n_sb = (int'(h_rx[0]) + int'(h_rx[1]) + int'(m_sync)) >= 2;
    end
    h_act[0] = h_act[1];
    h_edge[0] = h_edge[1];
    h_rx[0] = h_rx[1];
    h_act[1] = act;
    h_edge[1] = m_ec;
    h_rx[1] = m_sync;
    if (!ebe) begin
      m_ec = 0;
      m_bc = 0;
      m_bd = 1'b0;
    end else if (m_ec + 1 >= p) begin
      m_ec = 0;
      m_bd = 1'b1;
      m_bc = (m_bc < 31) ? m_bc + 1 : 31;
    end else begin
      m_ec = m_ec + 1;
      m_bd = 1'b0;
    end
    m_sb = n_sb;
    m_sv = n_sv;
    m_perr = !legal(p);
    rxq.push_back(rx_in);
    m_sync = rxq.pop_front();
  endtask

  task automatic check_all();
    chk("rx_sync", 32'(rx_sync), 32'(m_sync));
    chk("edge_count", 32'(edge_count), 32'(m_ec));
    chk("bit_count", 32'(bit_count), 32'(m_bc));
    chk("bit_done", 32'(bit_done), 32'(m_bd));
    chk("sampled_bit", 32'(sampled_bit), 32'(m_sb));
    chk("sample_valid", 32'(sample_valid), 32'(m_sv));
    chk("prescale_err", 32'(prescale_err), 32'(m_perr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    #2 rst_n = 1'b1;
  endtask

  function automatic bit glitch_pat(input int e);
    return !(e == 7 || e == 9);
  endfunction

  initial begin
    bit frame[10];
    bit votes[$];
    int cnt_a;
    int cnt_b;
    int max_ec;
    int r;
    n_pass = 0;
    n_checks = 0;
    frame = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset with the line toggling
    rst_n = 1'b0;
    rx_in = 1'b0;
    prescale = 6'd8;
    ebe = 1'b0;
    dse = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_in = ~rx_in;
      #1 check_all();
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    rx_in = 1'b1;
    tick();
    $display("reset released: rx_sync=%0b edge=%0d bit=%0d", rx_sync, edge_count, bit_count);

    // prescale 8 free-running counters
    ebe = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      chk("ec_seq", 32'(edge_count), 32'(i % 8));
      chk("bd_seq", 32'(bit_done), 32'(i % 8 == 0));
    end
    chk("bc_80", 32'(bit_count), 32'd10);
    ebe = 1'b0;
    tick();
    chk("ec_clr", 32'(edge_count), 32'd0);
    chk("bc_clr", 32'(bit_count), 32'd0);
    $display("counter run: 80 cycles at prescale 8 then clear");

    // frame 0xA5, LSB first, no parity
    rx_in = frame[0];
    ebe = 1'b1;
    dse = 1'b1;
    for (int i = 1; i <= 84; i++) begin
      tick();
      if (sample_valid) begin
        votes.push_back(sampled_bit);
        chk("sv_pos", 32'(edge_count), 32'd6);
        $display("frame vote bit=%0d value=%0b", bit_count, sampled_bit);
      end
      rx_in = (m_bc < 10) ? frame[m_bc] : 1'b1;
    end
    chk("frm_n", 32'(votes.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < votes.size()) chk("frm_bit", 32'(votes[k]), 32'(frame[k]));
    end

    // glitch vote at prescale 16
    ebe = 1'b0;
    dse = 1'b0;
    prescale = 6'd16;
    tick();
    votes.delete();
    ebe = 1'b1;
    dse = 1'b1;
    rx_in = glitch_pat(2);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (sample_valid) begin
        votes.push_back(sampled_bit);
        $display("glitch vote value=%0b", sampled_bit);
      end
      rx_in = glitch_pat((i + 2) % 16) ^ ((i + 2) / 16 == 1);
    end
    chk("glt_n", 32'(votes.size()), 32'd2);
    if (votes.size() == 2) begin
      chk("glt_010", 32'(votes[0]), 32'd0);
      chk("glt_101", 32'(votes[1]), 32'd1);
    end

    // prescale 4: vote coincides with bit_done
    ebe = 1'b0;
    dse = 1'b0;
    prescale = 6'd4;
    tick();
    ebe = 1'b1;
    dse = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 1; i <= 20; i++) begin
      rx_in = 1'($urandom_range(0, 1));
      tick();
      if (sample_valid && bit_done) cnt_a++;
      if (sample_valid && !bit_done) cnt_b++;
    end
    chk("p4_both", 32'(cnt_a), 32'd5);
    chk("p4_lone", 32'(cnt_b), 32'd0);
    $display("prescale 4: %0d coincident votes", cnt_a);

    // abort: data_sampler_enable low on the mid edge of bit 1
    ebe = 1'b0;
    dse = 1'b0;
    prescale = 6'd8;
    tick();
    ebe = 1'b1;
    dse = 1'b1;
    rx_in = 1'b0;
    cnt_a = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (sample_valid && i > 8 && i <= 16) cnt_a++;
      if (i == 16) begin
        chk("abt_sv", 32'(cnt_a), 32'd0);
        chk("abt_hold", 32'(sampled_bit), 32'd0);
      end
      dse = (i != 12);
      rx_in = (i >= 6);
    end
    chk("abt_resume", 32'(sampled_bit), 32'd1);
    $display("abort: bit 1 vote suppressed, bit 2 voted %0b", sampled_bit);

    // illegal prescale 10
    ebe = 1'b0;
    dse = 1'b0;
    tick();
    prescale = 6'd10;
    ebe = 1'b1;
    dse = 1'b1;
    tick();
    chk("perr_set", 32'(prescale_err), 32'd1);
    max_ec = 0;
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      rx_in = 1'($urandom_range(0, 1));
      tick();
      if (int'(edge_count) > max_ec) max_ec = int'(edge_count);
      if (sample_valid) cnt_a++;
    end
    chk("ill_max", 32'(max_ec), 32'd9);
    chk("ill_sv", 32'(cnt_a), 32'd0);
    ebe = 1'b0;
    prescale = 6'd8;
    tick();
    chk("perr_clr", 32'(prescale_err), 32'd0);
    $display("illegal prescale 10: max edge %0d", max_ec);

    // randomized segments
    for (int seg = 0; seg < 25; seg++) begin
      ebe = 1'b0;
      dse = 1'b0;
      tick();
      r = int'($urandom_range(0, 9));
      if (r < 8) prescale = 6'd4 << (r % 4);
      else prescale = 6'($urandom_range(0, 63));
      for (int i = 0; i < 150; i++) begin
        ebe = ($urandom_range(0, 99) < 97);
        dse = ($urandom_range(0, 99) < 90);
        if ($urandom_range(0, 3) == 0) rx_in = ~rx_in;
        if ($urandom_range(0, 499) == 0) mid_reset();
        tick();
        if (sample_valid) $display("seg %0d prescale %0d vote=%0b", seg, prescale, sampled_bit);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_edge_bit_sampler.md
Name: rx_edge_bit_sampler

Overview:
- Timing and sampling stage directly upstream of the UART RX control FSM.
- Synchronises the serial line and runs the oversampling edge counter and the frame bit counter, which feed the FSM's edge_count/bit_count inputs.
- Produces a majority-voted sampled bit per frame bit, consumed by the start/parity/stop checkers and the deserializer.
- Driven by the FSM's edge_bit_enable and data_sampler_enable strobes.

Parameters:
- PRESCALE_W, 6: width of prescale and edge_count.
- BIT_CNT_W, 5: width of bit_count.
- BIT_CNT_MAX, 31: saturation value of bit_count.

Ports:
- clk_based_on_prescale  in  1  oversampling clock.
- asy_reset  in  1  asynchronous active-low reset.
- RX_IN  in  1  raw asynchronous serial line; idles high.
- prescale  in  PRESCALE_W  oversampling ratio; legal values are 4, 8, 16, 32.
- edge_bit_enable  in  1  run the counters; low clears them.
- data_sampler_enable  in  1  enable the sample capture and vote.
- rx_sync  out  1  RX_IN after a 2-flop synchroniser; routed to the FSM RX_IN.
- edge_count  out  PRESCALE_W  oversample index within the current bit.
- bit_count  out  BIT_CNT_W  frame bit index (0 = start, 1..8 = data, 9 = parity or stop, 10 = stop).
- bit_done  out  1  one-cycle pulse on the edge_count wrap.
- sampled_bit  out  1  majority-voted value of the current bit.
- sample_valid  out  1  one-cycle pulse when sampled_bit updates.
- prescale_err  out  1  registered flag: prescale is not a legal value.

Behaviour:
- Reset and clock: asynchronous active-low reset on asy_reset; clock is clk_based_on_prescale; all flops are reset asynchronously.
- Reset values:
  - synchroniser flops = 1, so rx_sync = 1.
  - edge_count = 0, bit_count = 0, bit_done = 0.
  - sampled_bit = 1, sample_valid = 0, prescale_err = 0.
  - vote registers s0 = 1, s1 = 1.
- Synchroniser: 2 flops, so RX_IN reaches rx_sync with 2-cycle latency.
- All sampling in this block uses rx_sync, never the raw RX_IN.
- Counters, with edge_bit_enable = 0: next edge_count = 0 and bit_count = 0, regardless of any other input.
- Counters, with edge_bit_enable = 1 and edge_count >= prescale-1:
  - edge_count <= 0, bit_done <= 1.
  - bit_count <= bit_count+1, saturating at BIT_CNT_MAX.
  - The >= covers a prescale reduced mid-bit: it forces a wrap, never a runaway count.
- Counters, with edge_bit_enable = 1 otherwise: edge_count <= edge_count+1, bit_done <= 0.
- bit_done is 0 whenever no wrap occurs.
- Sampler: mid = prescale >> 1. Capture points, each only when data_sampler_enable = 1 and edge_bit_enable = 1:
  - edge_count == mid-1: s0 <= rx_sync.
  - edge_count == mid: s1 <= rx_sync.
  - edge_count == mid+1: sampled_bit <= majority(s0, s1, rx_sync), and sample_valid <= 1 for exactly one cycle.
- Sampler timing:
  - sampled_bit is visible on the cycle after edge_count == mid+1.
  - sampled_bit holds until the next vote.
  - For prescale = 4, the vote occurs at edge_count 3 = prescale-1, concurrently with bit_done.
- Sampler abort: if data_sampler_enable or edge_bit_enable drops mid-bit:
  - partial samples are discarded: s0 and s1 <= 1.
  - no sample_valid is produced; sampled_bit holds its last value.
- Re-enable mid-bit: the vote occurs only if all three capture points are reached while enabled. Otherwise no pulse until the next full bit.
- Illegal prescale: prescale_err <= 1 on every cycle where prescale is not in {4, 8, 16, 32}, else 0. In that case:
  - the counters still run, using the >= wrap rule;
  - the sampler is inhibited: no sample_valid pulses.
- Priority: edge_bit_enable = 0 clear beats wrap, increment and sampling.
- Reset mid-frame: all state returns to the reset values immediately, with no glitch on sample_valid.

Test Plan:
- Reset: hold asy_reset = 0 with RX_IN toggling, then release -> rx_sync = 1, edge_count = 0, bit_count = 0, sampled_bit = 1, sample_valid = 0.
- Prescale 8, edge_bit_enable held for 80 cycles:
  - edge_count sequence is 0..7 repeated;
  - bit_done pulses every 8th cycle;
  - bit_count reaches 10;
  - dropping enable clears both counters next cycle.
- Prescale 8, full frame 0x A5 LSB first with no parity, both enables high:
  - sample_valid pulses at edge_count 5 of each bit;
  - sampled_bit sequence is 0, 1,0,1,0,0,1,0,1, 1.
- Glitch vote at prescale 16: rx_sync = 0 at edge 7, 1 at edge 8, 0 at edge 9 -> sampled_bit = 0; pattern 1,0,1 -> sampled_bit = 1.
- Prescale 4 boundary: vote at edge 3 coincides with bit_done; both pulse on the same cycle.
- Abort and illegal: deassert data_sampler_enable at edge mid -> no sample_valid, sampled_bit held. Set prescale = 10 -> prescale_err = 1 next cycle, no sample_valid, counters wrap at 9.
